// File: rtl/muldiv_issue_ctrl.sv
// Issues RV32M ops to the iterative multiplier/divider; 2 cycles for divide special cases and cache hits, else unit time + 2.
// Backpressure: stall_e holds IF/ID/EX until the DONE cycle; a flushed op drains its unit before new ops issue.
module muldiv_issue_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int XLEN    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_e,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    input  logic              flush,
    output logic              stall_e,
    output logic              result_valid,
    output logic [XLEN-1:0]   result,
    output logic              timeout_err,
    output logic              mul_start,
    output logic              div_start,
    output logic              sign_a,
    output logic              sign_b,
    output logic [XLEN-1:0]   unit_a,
    output logic [XLEN-1:0]   unit_b,
    input  logic              mul_done,
    input  logic              div_done,
    input  logic [2*XLEN-1:0] mul_prod,
    input  logic [XLEN-1:0]   div_quot,
    input  logic [XLEN-1:0]   div_rem
);

    typedef enum logic [2:0] {IDLE, BUSY_MUL, BUSY_DIV, DONE, DRAIN} state_t;

    typedef struct packed {
        logic            vld;
        logic            sgn;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] quot;
        logic [XLEN-1:0] rem;
    } cache_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t        state, state_d;
    cache_t        cache;
    logic [CW-1:0] cnt;
    logic [1:0]    op_sel;
    logic          act_div;

    logic issue, is_div, is_rem, div_sgn, b_zero, ovf, hit, unit_done, wd_hit;

    assign issue     = (state == IDLE) && valid_e && !flush;
    assign is_div    = funct3[2];
    assign is_rem    = funct3[1];
    assign div_sgn   = !funct3[0];
    assign b_zero    = (op_b == '0);
    assign ovf       = div_sgn && (op_a == INT_MIN) && (op_b == '1);
    assign hit       = cache.vld && (cache.a == op_a) && (cache.b == op_b) && (cache.sgn == div_sgn);
    assign unit_done = act_div ? div_done : mul_done;
    assign wd_hit    = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state;
        stall_e      = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                stall_e = valid_e && !flush;
                if (issue) begin
                    if (!is_div)
                        state_d = BUSY_MUL;
                    else if (b_zero || ovf || hit)
                        state_d = DONE;
                    else
                        state_d = BUSY_DIV;
                end
            end
            BUSY_MUL, BUSY_DIV: begin
                stall_e = valid_e && !flush;
                // A result arriving with the flush belongs to the killed op, so nothing is left to drain.
                if (flush)
                    state_d = unit_done ? IDLE : DRAIN;
                else if (unit_done || wd_hit)
                    state_d = DONE;
            end
            DONE: begin
                result_valid = !flush;
                state_d      = IDLE;
            end
            DRAIN: begin
                stall_e = valid_e;
                if (unit_done || wd_hit)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst)
            stall_e = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cache       <= '0;
            cnt         <= '0;
            op_sel      <= '0;
            act_div     <= 1'b0;
            mul_start   <= 1'b0;
            div_start   <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            unit_a      <= '0;
            unit_b      <= '0;
            result      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_d;
            mul_start <= 1'b0;
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (issue) begin
                        op_sel <= funct3[1:0];
                        if (!is_div) begin
                            act_div   <= 1'b0;
                            mul_start <= 1'b1;
                            unit_a    <= op_a;
                            unit_b    <= op_b;
                            sign_a    <= (funct3[1:0] != 2'b11);
                            sign_b    <= !funct3[1];
                        end else if (b_zero) begin
                            result <= is_rem ? op_a : '1;
                        end else if (ovf) begin
                            result <= is_rem ? '0 : INT_MIN;
                        end else if (hit) begin
                            result <= is_rem ? cache.rem : cache.quot;
                        end else begin
                            act_div   <= 1'b1;
                            div_start <= 1'b1;
                            unit_a    <= op_a;
                            unit_b    <= op_b;
                            sign_a    <= div_sgn;
                            sign_b    <= div_sgn;
                        end
                    end
                end
                BUSY_MUL, BUSY_DIV: begin
                    cnt <= cnt + CW'(1);
                    if (!flush) begin
                        if (unit_done) begin
                            if (act_div) begin
                                result <= op_sel[1] ? div_rem : div_quot;
                                cache  <= '{vld: 1'b1, sgn: !op_sel[0], a: unit_a, b: unit_b,
                                            quot: div_quot, rem: div_rem};
                            end else begin
                                result <= (op_sel == 2'b00) ? mul_prod[XLEN-1:0]
                                                            : mul_prod[2*XLEN-1:XLEN];
                            end
                        end else if (wd_hit) begin
                            timeout_err <= 1'b1;
                            result      <= '0;
                        end
                    end
                end
                DRAIN: begin
                    cnt <= cnt + CW'(1);
                    if (!unit_done && wd_hit)
                        timeout_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
